// File: rtl/procik_pkg.sv
// procik_pkg: definitions shared by the procik-x1 datapath blocks.
//   N_DEFAULT / S_DEFAULT : default register width / register select width
//   op_t                  : 2-bit register operation code (regbank, control unit)
//   OP_LOAD/INC/DEC/CLR   : op_t encodings
package procik_pkg;

    localparam int N_DEFAULT = 8;
    localparam int S_DEFAULT = 3;

    typedef logic [1:0] op_t;

    localparam op_t OP_LOAD = 2'b00;
    localparam op_t OP_INC  = 2'b01;
    localparam op_t OP_DEC  = 2'b10;
    localparam op_t OP_CLR  = 2'b11;

endpackage

// File: rtl/procik_regop.sv
// procik_regop: combinational register operation unit.
//   op   in  : operation (LOAD/INC/DEC/CLR)
//   cur  in  : current register value
//   din  in  : LOAD operand
//   res  out : new register value
//   c    out : carry (INC wrap to 0) / borrow (DEC wrap to all-ones)
//   z    out : res == 0
module procik_regop
    import procik_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  op_t          op,
    input  logic [N-1:0] cur,
    input  logic [N-1:0] din,
    output logic [N-1:0] res,
    output logic         c,
    output logic         z
);

    always_comb begin
        res = cur;
        c   = 1'b0;
        case (op)
            OP_LOAD: res = din;
            // Extra top bit of the N+1-bit sum/difference is the carry/borrow.
            OP_INC:  {c, res} = {1'b0, cur} + (N+1)'(1);
            OP_DEC:  {c, res} = {1'b0, cur} - (N+1)'(1);
            OP_CLR:  res = '0;
            default: res = cur;
        endcase
    end

    assign z = (res == '0);

endmodule

// File: rtl/procik_regbank.sv
// procik_regbank: 8-entry x N-bit register bank feeding the 8-way operand mux.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   wr_en/wr_op/wr_addr/wr_data : one register operation per cycle
//   rd_req/rd_addr      : capture mux select
//   q0..q7              : register contents (mux data1..data8)
//   sel, sel_valid      : registered mux select, one-cycle pulse per request
//   flag_z, flag_c      : zero / carry of the last executed write
// Optional: define PROCIK_REGBANK_R0_ZERO_EN to hardwire register 0 to zero
// (writes to index 0 are dropped, flags included).
module procik_regbank
    import procik_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int S = S_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  op_t          wr_op,
    input  logic [S-1:0] wr_addr,
    input  logic [N-1:0] wr_data,
    input  logic         rd_req,
    input  logic [S-1:0] rd_addr,
    output logic [N-1:0] q0,
    output logic [N-1:0] q1,
    output logic [N-1:0] q2,
    output logic [N-1:0] q3,
    output logic [N-1:0] q4,
    output logic [N-1:0] q5,
    output logic [N-1:0] q6,
    output logic [N-1:0] q7,
    output logic [S-1:0] sel,
    output logic         sel_valid,
    output logic         flag_z,
    output logic         flag_c
);

    localparam int NREG = 1 << S;

    logic [NREG-1:0][N-1:0] rf;
    logic [N-1:0]           res;
    logic                   res_c;
    logic                   res_z;
    logic                   wr_exec;

    procik_regop #(.N(N)) u_regop (
        .op  (wr_op),
        .cur (rf[wr_addr]),
        .din (wr_data),
        .res (res),
        .c   (res_c),
        .z   (res_z)
    );

`ifdef PROCIK_REGBANK_R0_ZERO_EN
    // Index 0 is read-only zero: drop the whole write, flags included.
    assign wr_exec = wr_en && (wr_addr != '0);
`else
    assign wr_exec = wr_en;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf <= '0;
        end else if (wr_exec) begin
            for (int i = 0; i < NREG; i++)
                if (wr_addr == S'(i)) rf[i] <= res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else if (wr_exec) begin
            flag_z <= res_z;
            flag_c <= res_c;
        end
    end

    // Select updates on the same edge as the write, so a same-index
    // read/write presents the new value without a bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel       <= '0;
            sel_valid <= 1'b0;
        end else begin
            sel_valid <= rd_req;
            if (rd_req) sel <= rd_addr;
        end
    end

`ifdef PROCIK_REGBANK_R0_ZERO_EN
    assign q0 = '0;
`else
    assign q0 = rf[0];
`endif
    assign q1 = rf[1];
    assign q2 = rf[2];
    assign q3 = rf[3];
    assign q4 = rf[4];
    assign q5 = rf[5];
    assign q6 = rf[6];
    assign q7 = rf[7];

endmodule
